sub_shift_col_stream: RTL

- Sequential SubBytes + ShiftRows stage sitting directly upstream of the one-column MixColumns datapath.
- Accepts a full 128-bit AES state over a valid/ready handshake and emits the transformed state one 32-bit column per handshake, already laid out in MixColumns input format.
- Uses four S-box instances, time-shared over four column beats, so one block takes 4 output beats at full throughput.

---
 rtl/sub_shift_col_if.sv | 21 ++
 rtl/sub_shift_col_stream.sv | 106 ++++++++++
 2 files changed

// File: rtl/sub_shift_col_if.sv
// Stream bundle for the SubBytes/ShiftRows column stage: 128-bit state in, 32-bit columns out.
interface sub_shift_col_if;
   logic         s_valid;
   logic         s_ready;
   logic [127:0] s_data;
   logic         m_valid;
   logic         m_ready;
   logic [31:0]  m_col;
   logic [1:0]   m_col_idx;
   logic         m_last;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_col, m_col_idx, m_last
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_col, m_col_idx, m_last
   );
endinterface

// File: rtl/sub_shift_col_stream.sv
// SubBytes + optional ShiftRows on a buffered AES state, streamed out one MixColumns-ready column per beat.
// state | meaning
// IDLE  | buffer empty, s_ready high, no column on the output
// BUSY  | buffer holds a block, column col_cnt presented on m_col
module sub_shift_col_stream #(
   parameter bit SHIFT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   sub_shift_col_if.slave  bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [0:255][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[x];
   endfunction

   state_t       state_q, state_d;
   logic [127:0] state_buf_q, state_buf_d;
   logic [1:0]   col_cnt_q, col_cnt_d;
   logic         ready_en_q;
   logic         busy, beat, load;
   logic [1:0]   src_col [4];
   logic [7:0]   src_byte [4];
   logic [31:0]  col_sub;

   // ready_en_q keeps s_ready low through reset and for the release cycle itself
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         state_buf_q <= '0;
         col_cnt_q   <= '0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         state_buf_q <= state_buf_d;
         col_cnt_q   <= col_cnt_d;
         ready_en_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      state_buf_d = state_buf_q;
      col_cnt_d   = col_cnt_q;
      busy        = (state_q == BUSY);
      beat        = busy && bus.m_ready;
      bus.s_ready = ready_en_q && (!busy || (beat && col_cnt_q == 2'd3));
      load        = bus.s_valid && bus.s_ready;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_buf_d = bus.s_data;
               col_cnt_d   = 2'd0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (beat) begin
               col_cnt_d = col_cnt_q + 2'd1;
               if (col_cnt_q == 2'd3) begin
                  if (load) state_buf_d = bus.s_data;
                  else      state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // row r of the output column reads buffer column (col_cnt + r) mod 4 when shifting
   always_comb begin
      col_sub = '0;
      for (int r = 0; r < 4; r++) begin
         src_col[r]  = SHIFT_EN ? (col_cnt_q + 2'(r)) : col_cnt_q;
         src_byte[r] = state_buf_q[127 - 8*(4*int'(src_col[r]) + r) -: 8];
         col_sub[31 - 8*r -: 8] = sbox(src_byte[r]);
      end
   end

   assign bus.m_valid   = busy;
   assign bus.m_col     = busy ? col_sub : 32'd0;
   assign bus.m_col_idx = col_cnt_q;
   assign bus.m_last    = busy && (col_cnt_q == 2'd3);

endmodule
